// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio prefetch engine:
//   - state_t   : playback FSM states (IDLE, ARM, REQ, DONE)
//   - SDRAM_AW  : SDRAM word-address width
//   - SAMPLE_W  : PCM sample width
//   - min_words : helper that sizes a refill burst
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int SDRAM_AW = 25;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Smaller of two word counts; the last burst of a clip may be short.
    function automatic logic [SDRAM_AW-1:0] min_words(
        input logic [SDRAM_AW-1:0] a,
        input logic [SDRAM_AW-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage : audio_pkg

// File: rtl/audio_prefetch.sv
// ---------------------------------------------------------------------------
// audio_prefetch
// Streams a PCM clip from SDRAM into an external sample FIFO (shared with the
// I2S serializer). Whenever the FIFO drops below LOW_WATER words, one burst of
// up to BURST_LEN single-word reads is issued to the SDRAM arbiter and every
// acknowledged word is written straight into the FIFO.
//
// Parameters
//   FIFO_AW    width of the FIFO used-word counter
//   LOW_WATER  refill threshold in words
//   BURST_LEN  words fetched per refill
//
// Ports
//   clk           single clock, all logic on posedge
//   reset         asynchronous, active-high reset
//   start         one-cycle pulse, begins playback (ignored unless idle)
//   stop          one-cycle pulse, aborts playback (wins over start)
//   base_addr     first SDRAM word address of the clip
//   num_words     clip length in 16-bit words, 0 = empty clip
//   sdram_rd      read request to the arbiter, held until sdram_ac
//   sdram_addr    word address of the pending read
//   sdram_ac      one-cycle acknowledge, data valid in the same cycle
//   sdram_rddata  read data
//   fifo_wrreq    FIFO write strobe (combinational from sdram_ac)
//   fifo_data     sample written to the FIFO
//   fifo_wrusedw  FIFO fill level
//   fifo_wrfull   FIFO full flag
//   busy          high from start until playback ends
//   done          one-cycle pulse when the clip is exhausted
//
// Build option
//   PREFETCH_LOOP_EN  when defined, an exhausted clip restarts from base_addr
//                     (done pulses once per wrap, busy stays high until stop);
//                     when undefined, playback is one-shot.
// ---------------------------------------------------------------------------
module audio_prefetch
    import audio_pkg::*;
#(
    parameter int FIFO_AW   = 11,
    parameter int LOW_WATER = 1024,
    parameter int BURST_LEN = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [SDRAM_AW-1:0] base_addr,
    input  logic [SDRAM_AW-1:0] num_words,
    output logic                sdram_rd,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ac,
    input  logic [SAMPLE_W-1:0] sdram_rddata,
    output logic                fifo_wrreq,
    output logic [SAMPLE_W-1:0] fifo_data,
    input  logic [FIFO_AW-1:0]  fifo_wrusedw,
    input  logic                fifo_wrfull,
    output logic                busy,
    output logic                done
);

    localparam logic [SDRAM_AW-1:0] BURST_WORDS = SDRAM_AW'(BURST_LEN);
    localparam logic [31:0]         LOW_WATER_W = 32'(LOW_WATER);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t              r_state;
    logic [SDRAM_AW-1:0] r_ptr;        // address of the next word to read
    logic [SDRAM_AW-1:0] r_remaining;  // words left in the clip
    logic [SDRAM_AW-1:0] r_burst_cnt;  // words left in the current burst
    logic                r_sdram_rd;
    logic                r_busy;
    logic                r_done;

`ifdef PREFETCH_LOOP_EN
    // Clip descriptor kept for reloading at every wrap.
    logic [SDRAM_AW-1:0] r_base;
    logic [SDRAM_AW-1:0] r_num;
`endif

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic w_ac_take;     // acknowledge consumed by this engine
    logic w_room;        // FIFO wants a refill
    logic w_burst_end;   // this acknowledge completes the burst
    logic w_clip_end;    // this acknowledge completes the clip

    assign w_ac_take   = (r_state == REQ) && sdram_ac;
    assign w_room      = (32'(fifo_wrusedw) < LOW_WATER_W) && !fifo_wrfull;
    assign w_burst_end = w_ac_take && (r_burst_cnt == SDRAM_AW'(1));
    assign w_clip_end  = w_ac_take && (r_remaining == SDRAM_AW'(1));

    // The FIFO is written in the acknowledge cycle itself. A word acknowledged
    // while the FIFO is full is a protocol error: it is dropped here, but the
    // read still counts as consumed so the pointer stays aligned with the
    // arbiter.
    assign fifo_wrreq = w_ac_take && !fifo_wrfull;
    assign fifo_data  = sdram_rddata;

    assign sdram_rd   = r_sdram_rd;
    assign sdram_addr = r_ptr;
    assign busy       = r_busy;
    assign done       = r_done;

    // -----------------------------------------------------------------------
    // Playback FSM with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values; later assignments in the same branch
    // deliberately override earlier ones (e.g. the loop reload over ptr+1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: only plain registers exist here (no memory arrays), so the
            // whole datapath is reset, which also makes sdram_addr read 0.
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_burst_cnt <= '0;
            r_sdram_rd  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PREFETCH_LOOP_EN
            r_base      <= '0;
            r_num       <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_sdram_rd <= 1'b0;
                    if (start && !stop) begin
                        r_ptr       <= base_addr;
                        r_remaining <= num_words;
                        r_busy      <= 1'b1;
`ifdef PREFETCH_LOOP_EN
                        r_base      <= base_addr;
                        r_num       <= num_words;
`endif
                        if (num_words == '0) begin
                            // Empty clip: report completion without touching SDRAM.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ARM;
                        end
                    end
                end

                ARM: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_room) begin
                        r_burst_cnt <= min_words(BURST_WORDS, r_remaining);
                        r_sdram_rd  <= 1'b1;
                        r_state     <= REQ;
                    end
                end

                REQ: begin
                    if (w_ac_take) begin
                        r_ptr       <= r_ptr + SDRAM_AW'(1);
                        r_remaining <= r_remaining - SDRAM_AW'(1);
                        r_burst_cnt <= r_burst_cnt - SDRAM_AW'(1);
                    end

                    if (stop) begin
                        // A coincident acknowledge has already been written
                        // through fifo_wrreq; only the request is abandoned.
                        r_sdram_rd <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else if (w_burst_end) begin
                        r_sdram_rd <= 1'b0;
                        if (w_clip_end) begin
`ifdef PREFETCH_LOOP_EN
                            r_ptr       <= r_base;
                            r_remaining <= r_num;
                            r_done      <= 1'b1;
                            r_state     <= ARM;
`else
                            r_done      <= 1'b1;
                            r_state     <= DONE;
`endif
                        end else begin
                            r_state <= ARM;
                        end
                    end
                end

                DONE: begin
                    // done was raised on entry; it drops on the way out.
                    r_sdram_rd <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end

                default: begin
                    r_sdram_rd <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule : audio_prefetch

// File: tb/tb_audio_prefetch.sv
// ---------------------------------------------------------------------------
// tb_audio_prefetch
// Scoreboard bench for audio_prefetch with default parameters. Stimulus pushes
// the expected {address, sample} of every FIFO write into a queue; a monitor
// on the falling edge pops and compares whenever fifo_wrreq is high. A simple
// arbiter model acknowledges each read one cycle after it is seen and returns
// a sample derived from the address.
// ---------------------------------------------------------------------------
module tb_audio_prefetch;

    typedef struct {
        logic [24:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [24:0] base_addr;
    logic [24:0] num_words;
    logic        sdram_rd;
    logic [24:0] sdram_addr;
    logic        sdram_ac;
    logic [15:0] sdram_rddata;
    logic        fifo_wrreq;
    logic [15:0] fifo_data;
    logic [10:0] fifo_wrusedw;
    logic        fifo_wrfull;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int rd_rise = 0;
    logic prev_rd = 1'b0;
    exp_t exp_q[$];

    audio_prefetch #(
        .FIFO_AW  (11),
        .LOW_WATER(1024),
        .BURST_LEN(256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .sdram_rd    (sdram_rd),
        .sdram_addr  (sdram_addr),
        .sdram_ac    (sdram_ac),
        .sdram_rddata(sdram_rddata),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_data   (fifo_data),
        .fifo_wrusedw(fifo_wrusedw),
        .fifo_wrfull (fifo_wrfull),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [24:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [24:0] a);
        exp_t e;
        e.addr = a;
        e.data = pat(a);
        exp_q.push_back(e);
    endtask

    // Advance to 1 time unit after the next rising edge(s).
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [24:0] b, input logic [24:0] n);
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    // Arbiter model: acknowledge a pending read one cycle after it is seen.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            sdram_ac = 1'b0;
        end else if (sdram_rd && !sdram_ac) begin
            sdram_ac     = 1'b1;
            sdram_rddata = pat(sdram_addr);
        end else begin
            sdram_ac = 1'b0;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (sdram_rd && !prev_rd) rd_rise++;
        prev_rd = sdram_rd;
        if (done) done_cnt++;
        if (fifo_wrfull) check("no_wr_when_full", 32'(fifo_wrreq), 32'd0);
        if (fifo_wrreq) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                         sdram_addr, fifo_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(sdram_addr), 32'(e.addr));
                check("wr_data", 32'(fifo_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int r0;
        int n;

        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        base_addr    = '0;
        num_words    = '0;
        sdram_ac     = 1'b0;
        sdram_rddata = '0;
        fifo_wrusedw = '0;
        fifo_wrfull  = 1'b0;
        tick(3);

        // Reset state
        check("rst_rd",    32'(sdram_rd),   32'd0);
        check("rst_addr",  32'(sdram_addr), 32'd0);
        check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        reset = 1'b0;
        tick(2);

        // Short clip: 4 words from 0x100
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 4; i++) push_exp(25'h100 + 25'(i));
        pulse_start(25'h100, 25'd4);
        check("short_busy", 32'(busy), 32'd1);
        wait_writes(w0 + 4, 100, "short_writes");
        wait_done(d0 + 1, 20, "short_done");
        tick(2);
        check("short_idle",      32'(busy),            32'd0);
        check("short_done_once", 32'(done_cnt - d0),   32'd1);
        check("short_q_empty",   32'(exp_q.size()),    32'd0);

        // Low-water gating: no refill at 1024, one burst at 1023
        w0 = wr_cnt; d0 = done_cnt; r0 = rd_rise;
        fifo_wrusedw = 11'd1024;
        pulse_start(25'h2000, 25'd600);
        tick(30);
        check("lw_no_rd",   32'(rd_rise - r0), 32'd0);
        check("lw_no_wr",   32'(wr_cnt - w0),  32'd0);
        check("lw_busy",    32'(busy),         32'd1);
        pulse_start(25'h7777, 25'd5);   // ignored while busy
        for (int i = 0; i < 256; i++) push_exp(25'h2000 + 25'(i));
        fifo_wrusedw = 11'd1023;
        wait_writes(w0 + 1, 50, "lw_first_wr");
        fifo_wrusedw = 11'd1024;        // FIFO fills as the burst lands
        wait_writes(w0 + 256, 2000, "lw_burst");
        tick(20);
        check("lw_one_burst", 32'(wr_cnt - w0),  32'd256);
        check("lw_arm_rd",    32'(sdram_rd),     32'd0);
        check("lw_arm_busy",  32'(busy),         32'd1);
        check("lw_no_done",   32'(done_cnt - d0), 32'd0);
        pulse_stop();
        check("lw_stop_idle", 32'(busy), 32'd0);
        fifo_wrusedw = 11'd0;
        tick(2);

        // Stop coincident with the 3rd acknowledge
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 3; i++) push_exp(25'h3000 + 25'(i));
        pulse_start(25'h3000, 25'd10);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #2;
            if (sdram_ac && (wr_cnt - w0) == 2) break;
            n++;
        end
        check("stop_found_ac3", 32'(n < 100), 32'd1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stop_rd_low", 32'(sdram_rd), 32'd0);
        check("stop_idle",   32'(busy),     32'd0);
        tick(5);
        check("stop_writes",  32'(wr_cnt - w0),   32'd3);
        check("stop_no_done", 32'(done_cnt - d0), 32'd0);

        // Empty clip
        d0 = done_cnt; r0 = rd_rise;
        pulse_start(25'h55, 25'd0);
        wait_done(d0 + 1, 2, "empty_done");
        tick(2);
        check("empty_no_rd", 32'(rd_rise - r0), 32'd0);
        check("empty_idle",  32'(busy),         32'd0);

        // FIFO full holds off refill
        w0 = wr_cnt; d0 = done_cnt; r0 = rd_rise;
        fifo_wrfull = 1'b1;
        for (int i = 0; i < 2; i++) push_exp(25'h6000 + 25'(i));
        pulse_start(25'h6000, 25'd2);
        tick(20);
        check("full_no_rd",  32'(rd_rise - r0), 32'd0);
        check("full_no_wr",  32'(wr_cnt - w0),  32'd0);
        fifo_wrfull = 1'b0;
        wait_writes(w0 + 2, 50, "full_writes");
        wait_done(d0 + 1, 20, "full_done");

        // Asynchronous reset mid-burst, then restart from base_addr
        w0 = wr_cnt;
        tick(2);
        for (int i = 0; i < 8; i++) push_exp(25'h4000 + 25'(i));
        pulse_start(25'h4000, 25'd8);
        wait_writes(w0 + 2, 50, "rst_mid_pre");
        #2;
        reset = 1'b1;
        #1;
        check("arst_rd",    32'(sdram_rd),   32'd0);
        check("arst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("arst_addr",  32'(sdram_addr), 32'd0);
        check("arst_busy",  32'(busy),       32'd0);
        check("arst_done",  32'(done),       32'd0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(1);
        check("arst_no_more_wr", 32'(wr_cnt - w0), 32'd2);
        w0 = wr_cnt; d0 = done_cnt;
        push_exp(25'h5000);
        push_exp(25'h5001);
        pulse_start(25'h5000, 25'd2);
        wait_writes(w0 + 2, 50, "restart_writes");
        wait_done(d0 + 1, 20, "restart_done");
        tick(2);

        // Address wrap at the top of the 25-bit space
        w0 = wr_cnt; d0 = done_cnt;
`ifdef PREFETCH_LOOP_EN
        for (int i = 0; i < 7; i++) push_exp(25'h1FFFFFE + 25'(i % 3));
        pulse_start(25'h1FFFFFE, 25'd3);
        wait_writes(w0 + 7, 200, "loop_writes");
        check("loop_busy",      32'(busy),          32'd1);
        check("loop_done_wraps", 32'(done_cnt - d0), 32'd2);
        pulse_stop();
        tick(3);
        check("loop_stop_idle", 32'(busy),         32'd0);
        check("loop_q_empty",   32'(exp_q.size()), 32'd0);
`else
        push_exp(25'h1FFFFFE);
        push_exp(25'h1FFFFFF);
        push_exp(25'h0000000);
        pulse_start(25'h1FFFFFE, 25'd3);
        wait_writes(w0 + 3, 100, "wrap_writes");
        wait_done(d0 + 1, 20, "wrap_done");
        tick(2);
        check("wrap_idle",     32'(busy),         32'd0);
        check("wrap_q_empty",  32'(exp_q.size()), 32'd0);
`endif

        tick(3);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_audio_prefetch
